// File: rtl/ex_muldiv_ctrl_if.sv
// rtl/ex_muldiv_ctrl_if.sv - EX-stage mul/div request, result and stall bundle
//
// Purpose: groups the EX-stage request (start/op/operands), the pipeline
// hazard inputs (hilo_read/flush) and the sequencer outputs (busy, stall_req,
// done, div_by_zero, hi, lo) into one interface.
// Ports (signals):
//   start, op[1:0], operand_a, operand_b, hilo_read, flush  : pipeline -> sequencer
//   busy, stall_req, done, div_by_zero, hi, lo             : sequencer -> pipeline
// Modports: master = pipeline side, slave = sequencer side.
interface ex_muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             hilo_read;
    logic             flush;
    logic             busy;
    logic             stall_req;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, hilo_read, flush,
        input  busy, stall_req, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, hilo_read, flush,
        output busy, stall_req, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// rtl/ex_muldiv_ctrl.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO
//
// Purpose: runs one shift-add (multiply) or restoring shift-subtract (divide)
// step per clock on operand magnitudes, then applies sign correction and
// writes HI/LO. Total latency from accepted start to done is WIDTH+1 edges.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : ex_muldiv_ctrl_if.slave (request, hazard inputs, results, stall)
module ex_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    ex_muldiv_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;      // mul: {partial, multiplier}; div: {rem, quo}
    logic [WIDTH-1:0]   opnd_q;     // mul: multiplicand magnitude; div: divisor magnitude
    logic [WIDTH-1:0]   a_raw_q;    // raw dividend, returned in HI on divide by zero
    logic               is_div_q;
    logic               neg_q;      // negate product / quotient
    logic               neg_rem_q;  // negate remainder
    logic               dz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic               dz_out_q;

    // Request decode and operand magnitudes (unsigned ops keep raw bits).
    logic             req_signed;
    logic             req_div;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        req_signed = ~bus.op[0];
        req_div    = bus.op[1];
        sign_a     = req_signed & bus.operand_a[WIDTH-1];
        sign_b     = req_signed & bus.operand_b[WIDTH-1];
        mag_a      = sign_a ? (~bus.operand_a + 1'b1) : bus.operand_a;
        mag_b      = sign_b ? (~bus.operand_b + 1'b1) : bus.operand_b;
    end

    // One iteration step and the sign-corrected final result.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_d;
    logic [2*WIDTH:0]   div_sh;
    logic [WIDTH:0]     div_up;
    logic [WIDTH:0]     div_sub;
    logic [2*WIDTH-1:0] div_d;
    logic [2*WIDTH-1:0] step_d;
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0]   quo_c;
    logic [WIDTH-1:0]   rem_c;
    logic [2*WIDTH-1:0] res_d;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_d   = {mul_sum, acc_q[WIDTH-1:1]};

        // Shift {rem, quo} left; the carried-out bit joins the trial remainder.
        div_sh  = {acc_q, 1'b0};
        div_up  = div_sh[2*WIDTH:WIDTH];
        div_sub = div_up - {1'b0, opnd_q};
        div_d   = div_sh[2*WIDTH-1:0];
        if (div_up >= {1'b0, opnd_q}) begin
            div_d[2*WIDTH-1:WIDTH] = div_sub[WIDTH-1:0];
            div_d[0]               = 1'b1;
        end

        step_d = is_div_q ? div_d : mul_d;

        prod_c = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo_c  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_c  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
        if (dz_q) begin
            quo_c = {WIDTH{1'b1}};
            rem_c = a_raw_q;
        end
        res_d = is_div_q ? {rem_c, quo_c} : prod_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_out_q  <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            dz_out_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        state_q   <= RUN;
                        cnt_q     <= '0;
                        is_div_q  <= req_div;
                        neg_q     <= sign_a ^ sign_b;
                        neg_rem_q <= sign_a;
                        dz_q      <= req_div && (bus.operand_b == '0);
                        a_raw_q   <= bus.operand_a;
                        if (req_div) begin
                            acc_q  <= {{WIDTH{1'b0}}, mag_a};
                            opnd_q <= mag_b;
                        end else begin
                            acc_q  <= {{WIDTH{1'b0}}, mag_b};
                            opnd_q <= mag_a;
                        end
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q <= step_d;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            state_q <= FIX;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    // A squash arriving with the write cancels it entirely.
                    if (!bus.flush) begin
                        hi_q     <= res_d[2*WIDTH-1:WIDTH];
                        lo_q     <= res_d[WIDTH-1:0];
                        done_q   <= 1'b1;
                        dz_out_q <= dz_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.stall_req   = (state_q != IDLE) && (bus.hilo_read || bus.start);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_out_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule
